// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even/odd parity,
// then one or two stop bits, paced by an external oversample tick.
`timescale 1ns/1ps
module uart_tx_frame #(
   parameter int NB_DATA       = 8,
   parameter int N_TICKS       = 16,
   parameter int NB_TICK_COUNT = 6,
   parameter int NB_BIT_COUNT  = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_din,
   input  logic [1:0]         i_parity_mode,
   input  logic               i_two_stop,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_tx_done_tick
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [NB_TICK_COUNT-1:0] TICK_LAST = NB_TICK_COUNT'(N_TICKS - 1);
   localparam logic [NB_BIT_COUNT-1:0]  BIT_LAST  = NB_BIT_COUNT'(NB_DATA - 1);
   localparam logic [1:0]               MODE_EVEN = 2'b01;
   localparam logic [1:0]               MODE_ODD  = 2'b10;

   logic [2:0]               state,      state_n;
   logic [NB_TICK_COUNT-1:0] tick_cnt,   tick_cnt_n;
   logic [NB_BIT_COUNT-1:0]  bit_cnt,    bit_cnt_n;
   logic [NB_DATA-1:0]       shreg,      shreg_n;
   logic                     parity_en,  parity_en_n;
   logic                     parity_bit, parity_bit_n;
   logic                     two_stop,   two_stop_n;
   logic                     stop_idx,   stop_idx_n;
   logic                     tx,         tx_n;
   logic                     busy;
   logic                     done,       done_n;

   logic bit_end;
   assign bit_end = i_tick && (tick_cnt == TICK_LAST);

   // NOTE: every variable gets a default at the top of always_comb so no path leaves
   // one unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_n      = state;
      tick_cnt_n   = tick_cnt;
      bit_cnt_n    = bit_cnt;
      shreg_n      = shreg;
      parity_en_n  = parity_en;
      parity_bit_n = parity_bit;
      two_stop_n   = two_stop;
      stop_idx_n   = stop_idx;
      done_n       = 1'b0;

      case (state)
         ST_IDLE: begin
            // The done cycle is already IDLE but must not accept a new request.
            if (i_tx_start && !done) begin
               shreg_n      = i_din;
               parity_en_n  = (i_parity_mode == MODE_EVEN) || (i_parity_mode == MODE_ODD);
               parity_bit_n = (^i_din) ^ (i_parity_mode == MODE_ODD);
               two_stop_n   = i_two_stop;
               tick_cnt_n   = '0;
               stop_idx_n   = 1'b0;
               state_n      = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tick_cnt_n = '0;
               bit_cnt_n  = '0;
               state_n    = ST_DATA;
            end else if (i_tick) begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shreg_n    = shreg >> 1;
               tick_cnt_n = '0;
               if (bit_cnt == BIT_LAST) state_n = parity_en ? ST_PARITY : ST_STOP;
               else                     bit_cnt_n = bit_cnt + 1'b1;
            end else if (i_tick) begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               tick_cnt_n = '0;
               state_n    = ST_STOP;
            end else if (i_tick) begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               tick_cnt_n = '0;
               if (two_stop && !stop_idx) begin
                  stop_idx_n = 1'b1;
               end else begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end else if (i_tick) begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Line level follows the state being entered, so the pin register changes in step.
      case (state_n)
         ST_START:  tx_n = 1'b0;
         ST_DATA:   tx_n = shreg_n[0];
         ST_PARITY: tx_n = parity_bit_n;
         default:   tx_n = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_en  <= 1'b0;
         parity_bit <= 1'b0;
         two_stop   <= 1'b0;
         stop_idx   <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         tick_cnt   <= tick_cnt_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         parity_en  <= parity_en_n;
         parity_bit <= parity_bit_n;
         two_stop   <= two_stop_n;
         stop_idx   <= stop_idx_n;
         tx         <= tx_n;
         busy       <= (state_n != ST_IDLE);
         done       <= done_n;
      end
   end

   assign o_tx           = tx;
   assign o_busy         = busy;
   assign o_tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: an 8-bit/16-tick and a 5-bit/8-tick instance,
// frames predicted from line-format rules and compared tick by tick on the pin.
`timescale 1ns/1ps
module tb_uart_tx_frame;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          nt;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [1:0] start;
   logic [7:0] din;
   logic [1:0] mode;
   logic       two;
   logic [1:0] tx, busy, done;

   int checks   = 0;
   int failures = 0;
   int act      = 0;
   int tick_period = 1;
   int tick_ctr = 0;

   frame_t exp_q[$];

   always #5 clk = ~clk;

   uart_tx_frame #(.NB_DATA(8), .N_TICKS(16), .NB_TICK_COUNT(6), .NB_BIT_COUNT(4)) u_dut8 (
      .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start[0]),
      .i_din(din), .i_parity_mode(mode), .i_two_stop(two),
      .o_tx(tx[0]), .o_busy(busy[0]), .o_tx_done_tick(done[0]));

   uart_tx_frame #(.NB_DATA(5), .N_TICKS(8), .NB_TICK_COUNT(3), .NB_BIT_COUNT(3)) u_dut5 (
      .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start[1]),
      .i_din(din[4:0]), .i_parity_mode(mode), .i_two_stop(two),
      .o_tx(tx[1]), .o_busy(busy[1]), .o_tx_done_tick(done[1]));

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference frame: start 0, data LSB first, parity making the ones count even/odd, stops.
   function automatic frame_t model(input int nb, input int nt, input logic [7:0] d,
                                    input logic [1:0] m, input logic two_s);
      frame_t f;
      int ones = 0;
      int n = 1;
      f.bits = '0;
      f.nt = nt;
      for (int i = 0; i < nb; i++) begin
         f.bits[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (m == 2'b01) begin
         f.bits[n] = (ones % 2) == 1;
         n++;
      end else if (m == 2'b10) begin
         f.bits[n] = (ones % 2) == 0;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (two_s) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = n;
      return f;
   endfunction

   // Tick generator: fixed period, or random (~1 in 3) when tick_period is 0.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_ctr++;
         if (tick_period == 0) tick = ($urandom_range(0, 2) == 0);
         else                  tick = (tick_ctr % tick_period) == 0;
      end
   end

   // Monitor: collects the line value at every tick of a frame and scores it at done.
   logic   vals[$];
   logic   collecting = 1'b0;
   logic   prev_tx = 1'b1;
   logic   prev_tick = 1'b0;
   logic   done_prev = 1'b0;
   int     frames = 0;
   int     ones_w;
   frame_t e;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (collecting) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            collecting = 1'b0;
         end
         done_prev = 1'b0;
      end else begin
         if (done_prev) check("done_width", int'(done[act]), 0);
         done_prev = done[act];
         if (collecting) begin
            if (done[act]) begin
               collecting = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("f%0d_ticks", frames), vals.size(), e.nbits * e.nt);
                  if (vals.size() == e.nbits * e.nt) begin
                     for (int k = 0; k < e.nbits; k++) begin
                        ones_w = 0;
                        for (int j = 0; j < e.nt; j++) ones_w += int'(vals[k * e.nt + j]);
                        check($sformatf("f%0d_bit%0d_ones", frames, k), ones_w,
                              e.bits[k] ? e.nt : 0);
                     end
                  end
               end
            end else if (!busy[act]) begin
               check("busy_held", 0, 1);
               collecting = 1'b0;
            end else begin
               if (tx[act] != prev_tx) check("tx_change_after_tick", int'(prev_tick), 1);
               if (tick) vals.push_back(tx[act]);
            end
         end else if (busy[act]) begin
            collecting = 1'b1;
            frames++;
            vals.delete();
            check("start_entry_tx", int'(tx[act]), 0);
            if (tick) vals.push_back(tx[act]);
         end else if (done[act]) begin
            check("spurious_done", 1, 0);
         end
         prev_tx   = tx[act];
         prev_tick = tick;
      end
   end

   task automatic send(input int d, input logic [7:0] w, input logic [1:0] m, input logic t);
      act = d;
      din = w;
      mode = m;
      two = t;
      start[d] = 1'b1;
      exp_q.push_back(model(d == 0 ? 8 : 5, d == 0 ? 16 : 8, w, m, t));
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      din  = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      two  = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done[act] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done[act]) check("done_timeout", 0, 1);
   endtask

   task automatic gap();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = '0;
      din   = '0;
      mode  = '0;
      two   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_tx%0d", d),   int'(tx[d]),   1);
         check($sformatf("reset_busy%0d", d), int'(busy[d]), 0);
         check($sformatf("reset_done%0d", d), int'(done[d]), 0);
      end
      rst_n = 1'b1;
      gap();

      // Plain 8N1, then parity variants and two stop bits.
      send(0, 8'hA5, 2'b00, 1'b0); wait_done(400); gap();
      send(0, 8'hA5, 2'b01, 1'b1); wait_done(400); gap();
      send(0, 8'hA5, 2'b10, 1'b1); wait_done(400); gap();
      send(0, 8'h07, 2'b01, 1'b0); wait_done(400); gap();
      send(0, 8'h5A, 2'b11, 1'b1); wait_done(400); gap();

      // Slow ticks: each bit spans 64 clocks.
      tick_period = 4;
      send(0, 8'h3C, 2'b00, 1'b0); wait_done(1000); gap();
      tick_period = 1;

      // Requests while busy and in the done cycle are dropped.
      send(0, 8'h00, 2'b00, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      din = 8'hFF;
      start[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start[0] = 1'b0;
      wait_done(400);
      din = 8'hFF;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      send(0, 8'hFF, 2'b00, 1'b0); wait_done(400); gap();

      // Reset during data bit 3 aborts the frame without a done pulse.
      send(0, 8'hC3, 2'b01, 1'b0);
      repeat (70) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_tx",   int'(tx[0]),   1);
      check("abort_busy", int'(busy[0]), 0);
      check("abort_done", int'(done[0]), 0);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      send(0, 8'h96, 2'b10, 1'b1); wait_done(400); gap();

      // Narrow instance: 5 data bits, 8 ticks per bit.
      send(1, 8'h13, 2'b10, 1'b0); wait_done(200); gap();

      for (int i = 0; i < 12; i++) begin
         tick_period = $urandom_range(0, 3);
         send(0, 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         wait_done(2500);
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
      end
      for (int i = 0; i < 6; i++) begin
         tick_period = $urandom_range(0, 2);
         send(1, 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         wait_done(1500);
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
      end

      repeat (20) @(posedge clk);
      #1;
      check("pending_frames", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N2 transmitter in the UART path.
- Serialises one data word per request, LSB first, paced by an external baud tick (`i_tick`, one pulse per oversample period).
- Adds configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits, and a busy/done handshake.
- Sits between the TX buffer/ALU interface and the `o_tx` pin.

Parameters:
NB_DATA, 8, data word width in bits; legal 5..9
N_TICKS, 16, baud ticks per bit period; legal 2..64
NB_TICK_COUNT, 6, tick counter width; must satisfy 2**NB_TICK_COUNT >= N_TICKS
NB_BIT_COUNT, 4, data bit counter width; must satisfy 2**NB_BIT_COUNT > NB_DATA

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low (0 = reset)
i_tick  in  1  baud oversample tick, one-cycle pulse
i_tx_start  in  1  transmit request, sampled only in IDLE
i_din  in  NB_DATA  word to send, captured on accept
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; captured on accept
i_two_stop  in  1  0 = one stop bit, 1 = two stop bits; captured on accept
o_tx  out  1  serial line, registered, idle high
o_busy  out  1  high from accept cycle+1 until done
o_tx_done_tick  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (`i_reset`=0 at a clock edge):
  - state=IDLE; `o_tx`=1, `o_busy`=0, `o_tx_done_tick`=0; all counters and shift register cleared.
  - Reset mid-frame aborts the frame immediately; `o_tx` returns high the cycle after; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `o_tx`=1.
  - If `i_tx_start`=1: capture `i_din`, parity mode and `i_two_stop`; tick_cnt=0; go to START.
  - `i_tick` is irrelevant in IDLE.
- START:
  - `o_tx`=0.
  - On each `i_tick`: if tick_cnt==N_TICKS-1 then tick_cnt=0, bit_cnt=0, go to DATA; else tick_cnt+1.
- DATA:
  - `o_tx`=shreg[0].
  - On `i_tick` with tick_cnt==N_TICKS-1:
    - shift shreg right; tick_cnt=0.
    - If bit_cnt==NB_DATA-1: go to PARITY if mode is even/odd, else go to STOP.
    - Otherwise bit_cnt+1.
- PARITY:
  - `o_tx` = XOR of captured word (even mode) or its inverse (odd mode).
  - Lasts N_TICKS ticks, then go to STOP.
- STOP:
  - `o_tx`=1.
  - Lasts N_TICKS ticks (one stop bit) or 2*N_TICKS ticks (two stop bits); counted via stop-bit index, tick_cnt never exceeds N_TICKS-1.
  - On the final tick: `o_tx_done_tick`=1 for exactly that next cycle; go to IDLE.
- Frame duration:
  - Exactly (1 + NB_DATA + P + S) * N_TICKS ticks, where P∈{0,1} and S∈{1,2}.
  - `o_tx` changes only on the cycle after a tick that ends a bit, except the START entry edge, which follows accept by one clock.
- `o_busy`: 1 in every state except IDLE.
- `i_tx_start` while busy is ignored; no queueing.
- Start in the same cycle as the done pulse is ignored; the earliest accept is the first IDLE cycle.
- Input changes to `i_din`, `i_parity_mode` or `i_two_stop` after accept do not affect the frame in flight.
- `i_tick` coincident with the accept cycle is not counted.
- The parity bit is computed from the captured word, not the shifting register.

Test Plan:
1. NB_DATA=8, N_TICKS=16, `i_tick` every cycle, din=0xA5, mode 00, one stop → `o_tx` sequence per 16-tick bit: 0,1,0,1,0,0,1,0,1,1; done pulse after 160 ticks; `o_busy` high throughout.
2. din=0xA5, even parity, two stops → parity bit 0; frame 12 bits = 192 ticks. Same word with odd parity → parity bit 1. din=0x07 even → parity bit 1.
3. `i_tick` every 4th clock, din=0x3C → each bit holds 64 clocks; `o_tx` stable between ticks; done pulse is exactly 1 cycle wide.
4. Assert `i_tx_start` with din=0xFF during a 0x00 frame and in the done cycle → only 0x00 sent; next start in IDLE sends 0xFF normally.
5. Drive `i_reset`=0 during DATA bit 3 → next cycle `o_tx`=1, `o_busy`=0, no done pulse; the following start sends a full clean frame.
6. NB_DATA=5, N_TICKS=8, din=5'h13, odd parity, one stop → bits 0,1,1,0,0,1,0,1 (start, data LSB first, parity 0, stop); 64 ticks total.
